// File: rtl/command_parse_and_encapsulate_isc_mc.sv
// command_parse_and_encapsulate_isc_mc: CNT_NUM saturating packet counters, self-clearing control reg and port-enable mask behind fixed addresses, with 1-cycle registered read responses (ISC_CLEAR_ON_READ_EN: counter reads also clear the counter)
module command_parse_and_encapsulate_isc_mc #(
  parameter int CNT_NUM = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [18:0]        iv_addr,
  input  logic               i_addr_fixed,
  input  logic [31:0]        iv_wdata,
  input  logic               i_wr_irx,
  input  logic               i_rd_irx,
  input  logic [CNT_NUM-1:0] iv_pkt_pulse,
  output logic               o_wr_irx,
  output logic [18:0]        ov_addr_irx,
  output logic               o_addr_fixed_irx,
  output logic [31:0]        ov_rdata_irx,
  output logic [CNT_NUM-1:0] ov_port_en
);
  localparam logic [18:0] CTL_ADDR = 19'(CNT_NUM);
  localparam logic [18:0] MSK_ADDR = 19'(CNT_NUM + 1);
  logic [CNT_WIDTH-1:0] cnt [CNT_NUM];
  logic [CNT_NUM-1:0] inc;
  logic [31:0] rdata;
  logic wr, rd, clr, resp, unused_wdata;
  assign wr = i_wr_irx && i_addr_fixed;
  assign rd = i_rd_irx && !i_wr_irx && i_addr_fixed && iv_addr <= MSK_ADDR;
  assign clr = wr && iv_addr == CTL_ADDR && iv_wdata[0];
  assign inc = iv_pkt_pulse & ov_port_en;
  assign resp = i_rst_n && rd;
  assign unused_wdata = &{1'b0, iv_wdata};
  always_comb begin
    rdata = iv_addr == MSK_ADDR ? 32'(ov_port_en) : '0;
    for (int n = 0; n < CNT_NUM; n++)
      if (iv_addr == 19'(n)) rdata = 32'(cnt[n]);
  end
  always_ff @(posedge i_clk)
    for (int n = 0; n < CNT_NUM; n++)
      if (!i_rst_n || clr) cnt[n] <= '0;
`ifdef ISC_CLEAR_ON_READ_EN
      else if (rd && iv_addr == 19'(n)) cnt[n] <= CNT_WIDTH'(inc[n]);
`endif
      else if (inc[n] && !(&cnt[n])) cnt[n] <= cnt[n] + CNT_WIDTH'(1);
  always_ff @(posedge i_clk)
    if (!i_rst_n) ov_port_en <= '1;
    else if (wr && iv_addr == MSK_ADDR) ov_port_en <= iv_wdata[CNT_NUM-1:0];
  always_ff @(posedge i_clk) begin
    o_wr_irx <= resp;
    o_addr_fixed_irx <= resp;
    ov_addr_irx <= resp ? iv_addr : '0;
    ov_rdata_irx <= resp ? rdata : '0;
  end
endmodule
